mem_access_ctrl: RTL
====================

# mem_access_ctrl

Memory access controller sitting directly upstream of `ram_256b`: it accepts one load/store request at a time from the CPU control unit and runs the four-phase MFA/MFC handshake. It drives `opcode`, `addr` and `data_in` into the RAM and synchronises the RAM's asynchronous MFC. It captures `data_out` into a read-data register and reports completion, misalignment, bad opcodes and timeouts back to the control unit.

## Interface
- `TIMEOUT`, default 64: clock cycles allowed per handshake phase before abort.
- `clk` input 1: system clock, rising edge.
- `reset` input 1: asynchronous, active-high.
- `req` input 1: start a transaction; sampled only in IDLE.
- `op_in` input 6: RAM opcode.
- `addr_in` input 8: byte address.
- `wdata` input 32: store data; the low byte or halfword is used for sub-word stores.
- `busy` output 1: high whenever state is not IDLE.
- `done` output 1: one-cycle completion pulse.
- `err` output 1: valid with `done`; high on misalignment, bad opcode or timeout.
- `rdata` output 32: captured load data; holds until the next successful load.
- `MFA` output 1: memory function active, to RAM.
- `opcode` output 6: to RAM.
- `addr` output 8: to RAM.
- `data_in` output 32: to RAM.
- `MFC` input 1: memory function complete, from RAM; asynchronous to `clk`.
- `data_out` input 32: from RAM; stable while MFC is high.

## Operation
- Valid opcodes:
  - Stores: 0x05 SB, 0x06 SH, 0x04 SW.
  - Loads: 0x01 LBU, 0x09 LB, 0x02 LHU, 0x0A LH, 0x08 LW.
  - Any other value is a bad opcode.
- Alignment rules: SH/LHU/LH require `addr_in[0]`=0. SW/LW require `addr_in[1:0]`=0. Byte ops have no constraint.
- State machine and transitions:
  - IDLE: on `req`, register `op_in`/`addr_in`/`wdata`. A bad opcode or misalignment goes to DONE with an error flag set, and MFA is never raised. Otherwise go to SETUP.
  - SETUP: one cycle with `opcode`/`addr`/`data_in` driven and MFA=0, giving address and data setup before MFA. Then go to WAIT.
  - WAIT: MFA=1. When synchronised MFC=1: latch `data_out` into `rdata` if the op is a load, drop MFA, go to RELEASE.
  - RELEASE: MFA=0. When synchronised MFC=0, go to DONE.
  - DONE: `done`=1 for one cycle, `err` = error flag, then go to IDLE.
- Timeout:
  - One counter, cleared on entry to WAIT and on entry to RELEASE.
  - Counter reaching TIMEOUT-1 in WAIT: set the error flag, drop MFA, go to RELEASE with no `rdata` update.
  - Counter reaching TIMEOUT-1 in RELEASE: go to DONE with the error flag set.
- `req` asserted while `busy` is ignored, not queued.
- The RAM-side outputs hold their registered values from SETUP through DONE. MFA is the only one that changes.

## Timing
- Reset values:
  - `MFA`=0, `busy`=0, `done`=0, `err`=0.
  - `rdata`=0, `opcode`=0, `addr`=0, `data_in`=0.
  - State IDLE, synchroniser flops 0, timeout counter 0.
- Reset mid-transaction drops MFA asynchronously. A late MFC from the RAM is then absorbed: IDLE ignores MFC.
- MFC passes through a 2-flop synchroniser, adding 2 cycles of latency on each edge.
- Minimum latency, with a zero-delay RAM: `req` sampled at edge 0, MFA rises after edge 2, RELEASE after edge 5, `done` high in the cycle after edge 8.
- Error in IDLE: `done`/`err` high in the cycle after edge 1.
- `rdata` updates at the same edge MFA falls, and is visible together with `done`.
- Back-to-back: `req` can be accepted in the cycle after `done` deasserts. MFA is never high two consecutive transactions without an intervening low of at least 4 cycles.

## Structure
- Shared package `mem_pkg` holds:
  - Opcode localparams (`OP_SB`…`OP_LW`).
  - The state encoding.
  - An `is_valid_op` function and an `is_aligned` function, reused by the decode stage.
- Sub-module `mfc_sync`: 2-flop synchroniser, asynchronous active-high reset to 0.
- The timeout counter width is `$clog2(TIMEOUT)`, with saturation.

## Test plan
- SB 0x01@0x00 then SB 0x23@0x01, RAM MFC delay 3 cycles: each yields one MFA pulse, `opcode`=0x05, `done` with `err`=0.
- SH 0x4567@0x02, then LHU@0x02: `rdata`=0x00004567. LH@0x06 with memory 0xCDEF: `rdata`=0xFFFFCDEF, passed through from the RAM unchanged.
- LW@0x03: `done`+`err` the cycle after edge 1, MFA never asserted, `rdata` unchanged. `op_in`=0x07 produces the same response.
- RAM never raises MFC, TIMEOUT=8: MFA drops after 8 WAIT cycles, then `done`+`err`, return to IDLE.
- Async `reset` pulse while MFA=1: MFA=0 immediately and all outputs at reset values. The next SW 0x123ABCDF@0x04 completes with `err`=0.
- `req` held high through 3 transactions: exactly 3 `done` pulses, `req` ignored while `busy`=1.

Source files
------------

// File: rtl/mem_pkg.sv
// Shared definitions for the RAM access controller: opcodes, FSM encoding and
// request decode helpers.
package mem_pkg;

    localparam logic [5:0] OP_LBU = 6'h01;
    localparam logic [5:0] OP_LHU = 6'h02;
    localparam logic [5:0] OP_SW  = 6'h04;
    localparam logic [5:0] OP_SB  = 6'h05;
    localparam logic [5:0] OP_SH  = 6'h06;
    localparam logic [5:0] OP_LW  = 6'h08;
    localparam logic [5:0] OP_LB  = 6'h09;
    localparam logic [5:0] OP_LH  = 6'h0A;

    typedef enum logic [2:0] {
        StIdle,
        StDecode,
        StSetup,
        StWait,
        StRelease,
        StDone
    } state_e;

    function automatic logic is_load(input logic [5:0] op);
        case (op)
            OP_LBU, OP_LB, OP_LHU, OP_LH, OP_LW: return 1'b1;
            default:                             return 1'b0;
        endcase
    endfunction

    function automatic logic is_store(input logic [5:0] op);
        case (op)
            OP_SB, OP_SH, OP_SW: return 1'b1;
            default:             return 1'b0;
        endcase
    endfunction

    function automatic logic is_valid_op(input logic [5:0] op);
        return is_load(op) || is_store(op);
    endfunction

    // Only the two low address bits matter for natural alignment.
    function automatic logic is_aligned(input logic [5:0] op, input logic [1:0] addr_lo);
        case (op)
            OP_SH, OP_LHU, OP_LH: return addr_lo[0] == 1'b0;
            OP_SW, OP_LW:         return addr_lo == 2'b00;
            default:              return 1'b1;
        endcase
    endfunction

endpackage

// File: rtl/mem_access_ctrl_if.sv
// RAM-side bus of the access controller: request lines out, MFC/read data back.
interface mem_access_ctrl_if;

    logic        MFA;
    logic [5:0]  opcode;
    logic [7:0]  addr;
    logic [31:0] data_in;
    logic        MFC;
    logic [31:0] data_out;

    modport master (
        output MFA,
        output opcode,
        output addr,
        output data_in,
        input  MFC,
        input  data_out
    );

    modport slave (
        input  MFA,
        input  opcode,
        input  addr,
        input  data_in,
        output MFC,
        output data_out
    );

endinterface

// File: rtl/mfc_sync.sv
// Two-flop synchroniser for the RAM's asynchronous MFC line.
module mfc_sync (
    input  logic clk,
    input  logic reset,
    input  logic async_in,
    output logic sync_out
);

    logic meta_q;
    logic sync_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            meta_q <= 1'b0;
            sync_q <= 1'b0;
        end else begin
            meta_q <= async_in;
            sync_q <= meta_q;
        end
    end

    assign sync_out = sync_q;

endmodule

// File: rtl/mem_access_ctrl.sv
// Memory access controller: one load/store at a time over the four-phase MFA/MFC
// handshake, with decode checks, per-phase timeout and a read-data register.
module mem_access_ctrl
    import mem_pkg::*;
#(
    parameter int unsigned TIMEOUT = 64
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                req,
    input  logic [5:0]          op_in,
    input  logic [7:0]          addr_in,
    input  logic [31:0]         wdata,
    output logic                busy,
    output logic                done,
    output logic                err,
    output logic [31:0]         rdata,
    mem_access_ctrl_if.master   ram
);

    localparam int unsigned CntW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [CntW-1:0] CntMax = CntW'(TIMEOUT - 1);

    state_e          state_q;
    logic [5:0]      op_q;
    logic [7:0]      addr_q;
    logic [31:0]     wdata_q;
    logic            err_flag_q;
    logic [CntW-1:0] cnt_q;
    logic            mfa_q;
    logic            done_q;
    logic            err_q;
    logic [31:0]     rdata_q;
    logic [5:0]      opcode_q;
    logic [7:0]      ram_addr_q;
    logic [31:0]     data_in_q;
    logic            mfc_s;

    mfc_sync u_mfc_sync (
        .clk      (clk),
        .reset    (reset),
        .async_in (ram.MFC),
        .sync_out (mfc_s)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= StIdle;
            op_q       <= '0;
            addr_q     <= '0;
            wdata_q    <= '0;
            err_flag_q <= 1'b0;
            cnt_q      <= '0;
            mfa_q      <= 1'b0;
            done_q     <= 1'b0;
            err_q      <= 1'b0;
            rdata_q    <= '0;
            opcode_q   <= '0;
            ram_addr_q <= '0;
            data_in_q  <= '0;
        end else begin
            done_q <= 1'b0;
            err_q  <= 1'b0;
            unique case (state_q)
                StIdle: begin
                    if (req) begin
                        op_q    <= op_in;
                        addr_q  <= addr_in;
                        wdata_q <= wdata;
                        state_q <= StDecode;
                    end
                end
                StDecode: begin
                    // Rejected requests never touch the RAM-side registers or MFA.
                    if (!is_valid_op(op_q) || !is_aligned(op_q, addr_q[1:0])) begin
                        err_flag_q <= 1'b1;
                        done_q     <= 1'b1;
                        err_q      <= 1'b1;
                        state_q    <= StDone;
                    end else begin
                        err_flag_q <= 1'b0;
                        opcode_q   <= op_q;
                        ram_addr_q <= addr_q;
                        data_in_q  <= wdata_q;
                        state_q    <= StSetup;
                    end
                end
                StSetup: begin
                    mfa_q   <= 1'b1;
                    cnt_q   <= '0;
                    state_q <= StWait;
                end
                StWait: begin
                    if (mfc_s) begin
                        if (is_load(opcode_q)) begin
                            rdata_q <= ram.data_out;
                        end
                        mfa_q   <= 1'b0;
                        cnt_q   <= '0;
                        state_q <= StRelease;
                    end else if (cnt_q == CntMax) begin
                        err_flag_q <= 1'b1;
                        mfa_q      <= 1'b0;
                        cnt_q      <= '0;
                        state_q    <= StRelease;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                StRelease: begin
                    if (!mfc_s) begin
                        done_q  <= 1'b1;
                        err_q   <= err_flag_q;
                        state_q <= StDone;
                    end else if (cnt_q == CntMax) begin
                        err_flag_q <= 1'b1;
                        done_q     <= 1'b1;
                        err_q      <= 1'b1;
                        state_q    <= StDone;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                StDone: begin
                    state_q <= StIdle;
                end
                default: begin
                    state_q <= StIdle;
                end
            endcase
        end
    end

    assign busy  = (state_q != StIdle);
    assign done  = done_q;
    assign err   = err_q;
    assign rdata = rdata_q;

    assign ram.MFA     = mfa_q;
    assign ram.opcode  = opcode_q;
    assign ram.addr    = ram_addr_q;
    assign ram.data_in = data_in_q;

endmodule
